packed_word_fifo: RTL and testbench
===================================

# packed_word_fifo

Synchronous FIFO that buffers the 32-bit words produced by the byte-packing shift register. It sits directly downstream of the packer: the packer's `valid_fifo` strobe drives `wr_en` and its `data_out` drives `wr_data`. A downstream consumer drains the words with a registered read port. The FIFO reports occupancy and keeps sticky error flags for dropped writes and rejected reads.

## Interface
- `WIDTH`, 32: word width in bits.
- `DEPTH`, 8: number of entries; must be a power of two, at least 2.
- `ADDR_W`, 3: log2(`DEPTH`); pointer width.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `wr_en` input 1: write strobe; driven by the packer's `valid_fifo`.
- `wr_data` input `WIDTH`: word to write; driven by the packer's `data_out`.
- `rd_en` input 1: read request from the consumer.
- `rd_data` output `WIDTH`: registered read word.
- `rd_valid` output 1: `rd_data` holds a word popped on the previous edge.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `count` output `ADDR_W+1`: current occupancy, 0 to `DEPTH`.
- `overflow` output 1: sticky; a write was dropped.
- `underflow` output 1: sticky; a read was rejected.

## Operation
- **Storage and pointers**
  - Storage is a `DEPTH` x `WIDTH` register array.
  - Write pointer `wp` and read pointer `rp` are `ADDR_W` bits wide and wrap naturally from `DEPTH-1` to 0.
  - `count` is kept as a separate register.
- **Read acceptance**
  - `rd_ok = rd_en & ~empty`.
- **Write acceptance**
  - `wr_ok = wr_en & (~full | rd_ok)`.
  - When full, a write is accepted only together with an accepted read (pass-through at capacity).
- **On `wr_ok`**
  - `mem[wp] <= wr_data`.
  - `wp <= wp + 1`.
- **On `rd_ok`**
  - `rd_data <= mem[rp]`.
  - `rp <= rp + 1`.
  - `rd_valid <= 1`.
  - Otherwise `rd_valid <= 0` and `rd_data` holds its value.
- **Count update**
  - `count <= count + wr_ok - rd_ok`.
  - Simultaneous accepted read and write leaves `count` unchanged.
- **Flags**
  - `full` and `empty` are decoded from the registered `count`, so they are glitch-free.
- **Sticky error flags**
  - `overflow` sets when `wr_en & ~wr_ok`.
  - `underflow` sets when `rd_en & empty`.
  - Both clear only on `rst`.
- **Empty with simultaneous read and write**
  - The write is accepted and the read is rejected; `underflow` sets.
  - No fall-through: the new word is readable from the next cycle.
- **Reset values** (`rst` has priority over all other activity)
  - `wp = rp = 0`, `count = 0`.
  - `empty = 1`, `full = 0`.
  - `rd_data = 0`, `rd_valid = 0`.
  - `overflow = 0`, `underflow = 0`.
  - The storage array is not cleared.
- **Reset mid-operation**
  - All buffered words are discarded.
  - A `wr_en` or `rd_en` asserted during the reset cycle is ignored and does not set the error flags.

## Timing
- **Write latency**
  - A word written at edge N raises `count` and deasserts `empty` after edge N.
  - The earliest accepted read is at edge N+1, with data visible after N+1.
- **Read latency**
  - One cycle: `rd_en` sampled at edge N gives `rd_data`/`rd_valid` valid after edge N, for one cycle per accepted read.
- **Throughput**
  - One write and one read per cycle.
- **Back-to-back reads**
  - `rd_valid` stays high and `rd_data` updates every cycle.
- **Inputs**
  - `wr_en` and `wr_data` are sampled only on rising edges; the packer's output timing needs no extra alignment.
  - No combinational path from inputs to outputs.
- **Wrap-around**
  - After `DEPTH` writes, `wp` returns to 0.
  - Ordering is preserved across arbitrary pointer wraps.

## Test plan
1. **Reset:** hold `rst` 2 cycles with `wr_en=1`, `rd_en=1` -> `empty=1`, `full=0`, `count=0`, `rd_valid=0`, `rd_data=0`, `overflow=0`, `underflow=0`.
2. **Fill and drain:** write 0x04030201, 0x08070605, … (8 words) -> `full=1`, `count=8`. Then assert `rd_en` for 8 cycles -> `rd_data` returns the words in order, one per cycle, each one cycle after its `rd_en`; afterwards `empty=1`.
3. **Overflow:** with the FIFO full, write 0xDEADBEEF with `rd_en=0` -> word dropped, `overflow=1` and held, `count` stays 8; the next 8 reads never return 0xDEADBEEF.
4. **Underflow and empty simultaneous access:**
   - Read while empty -> `rd_valid=0`, `underflow=1`.
   - Write 0x11111111 together with `rd_en` while empty -> write accepted, `count=1`.
   - Read on the next cycle returns 0x11111111.
5. **Full pass-through:** with the FIFO full, assert `wr_en` (0xAAAA5555) and `rd_en` together -> oldest word read, new word stored, `count=8`, `overflow=0`. Drain -> 0xAAAA5555 emerges last.
6. **Wrap and mid-reset:**
   - Stream 20 words with 3 reads per 4 writes -> order preserved through pointer wraps.
   - Assert `rst` with 5 words stored -> `count=0`, `empty=1` after the edge; old data is never read.

Source files
------------

// File: rtl/packed_word_fifo_if.sv
// packed_word_fifo_if
//   Bundle of the write/read handshake between the byte packer, the word FIFO
//   and the downstream consumer.
//   master : producer/consumer side (drives wr_en, wr_data, rd_en)
//   slave  : FIFO side (drives rd_data, rd_valid, full, empty, count, flags)
interface packed_word_fifo_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/packed_word_fifo.sv
// packed_word_fifo
//   Synchronous FIFO buffering 32-bit words from the byte packer. Registered
//   read port (one-cycle latency), separate occupancy counter, sticky
//   overflow/underflow flags.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : packed_word_fifo_if.slave
//         in : wr_en, wr_data, rd_en
//         out: rd_data, rd_valid, full, empty, count, overflow, underflow
module packed_word_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  packed_word_fifo_if.slave  bus
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [ADDR_W-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_W:0]             count_q, count_d;
  logic [WIDTH-1:0]            rd_data_q, rd_data_d;
  logic                        rd_valid_q, rd_valid_d;
  logic                        ovf_q, ovf_d, unf_q, unf_d;
  logic                        full, empty, rd_ok, wr_ok;

  // Flags decode from the registered count only: no input-to-output path.
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    rd_ok      = bus.rd_en & ~empty;
    // At capacity a write gets in only by riding along with a read.
    wr_ok      = bus.wr_en & (~full | rd_ok);
    wp_d       = wr_ok ? wp_q + 1'b1 : wp_q;
    rp_d       = rd_ok ? rp_q + 1'b1 : rp_q;
    count_d    = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    rd_valid_d = rd_ok;
    rd_data_d  = rd_ok ? mem_q[rp_q] : rd_data_q;
    ovf_d      = ovf_q | (bus.wr_en & ~wr_ok);
    unf_d      = unf_q | (bus.rd_en & empty);
  end

  // Storage is deliberately not cleared; pointers/count make stale data
  // unreachable after reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wp_q] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_packed_word_fifo.sv
// tb_packed_word_fifo
//   Directed stimulus with a scoreboard: each accepted read pushes the word it
//   must return; a negedge monitor pops and compares whenever rd_valid is high.
module tb_packed_word_fifo;
  localparam int WIDTH = 32, DEPTH = 8, ADDR_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  packed_word_fifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  packed_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] mq [$];   // words the FIFO should be holding
  logic [WIDTH-1:0] exp_q [$]; // words the read port owes us

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: rd_valid must only appear for a word the scoreboard expects.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected: got 0x%08h expected no rd_valid", bus.rd_data);
      end else begin
        chk("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  // One clock: drive inputs, let the edge happen, update the reference
  // queue, return at the following negedge.
  task automatic step(input logic rs, input logic we, input logic [31:0] wd, input logic re);
    logic rok, wok;
    rst = rs; bus.wr_en = we; bus.wr_data = wd; bus.rd_en = re;
    rok = re && (mq.size() > 0);
    wok = we && ((mq.size() < DEPTH) || rok);
    @(posedge clk);
    if (rs) mq.delete();
    else begin
      if (rok) exp_q.push_back(mq.pop_front());
      if (wok) mq.push_back(wd);
    end
    @(negedge clk);
  endtask

  task automatic idle(); step(1'b0, 1'b0, 32'h0, 1'b0); endtask

  task automatic drained(input string name);
    idle();
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  logic [31:0] w;

  initial begin
    rst = 1'b1; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
    @(negedge clk);

    // 1. reset with both strobes high
    step(1'b1, 1'b1, 32'hCAFE0001, 1'b1);
    step(1'b1, 1'b1, 32'hCAFE0002, 1'b1);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_underflow", bus.underflow, 0);

    // 2. fill and drain
    for (int i = 0; i < 8; i++) begin
      w = 32'h04030201 + i * 32'h04040404;
      step(1'b0, 1'b1, w, 1'b0);
      if (i == 0) begin
        chk("wr1_count", bus.count, 1);
        chk("wr1_empty", bus.empty, 0);
      end
    end
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_empty", bus.empty, 1);
    drained("drain");
    chk("drain_underflow", bus.underflow, 0);

    // 3. overflow
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h10000000 + i, 1'b0);
    step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_count", bus.count, 8);
    idle();
    chk("ovf_held", bus.overflow, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    drained("ovf");
    chk("ovf_empty", bus.empty, 1);

    // 4. underflow / empty simultaneous access
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("unf_rd_valid", bus.rd_valid, 0);
    chk("unf_flag", bus.underflow, 1);
    step(1'b0, 1'b1, 32'h11111111, 1'b1);
    chk("empty_wr_count", bus.count, 1);
    chk("empty_wr_rd_valid", bus.rd_valid, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("empty_wr_read", bus.rd_data, 32'h11111111);
    drained("unf");

    // 5. full pass-through
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h20000000 + i, 1'b0);
    step(1'b0, 1'b1, 32'hAAAA5555, 1'b1);
    chk("pass_count", bus.count, 8);
    chk("pass_overflow", bus.overflow, 0);
    chk("pass_oldest", bus.rd_data, 32'h20000000);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pass_last", bus.rd_data, 32'hAAAA5555);
    drained("pass");

    // 6. wrap streaming, then reset with 5 words stored
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 32'h30000000 + i * 32'h01010101, (i % 4) != 0);
    chk("wrap_count", bus.count, 5);
    drained("wrap");
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_count", bus.count, 0);
    chk("mrst_empty", bus.empty, 1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mrst_no_old_data", bus.rd_valid, 0);
    chk("mrst_underflow", bus.underflow, 1);
    drained("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
